// File: rtl/fir_tap_sequencer_pkg.sv
// Shared types and helpers for the FIR tap sequencer.
// Also holds the address-width rule and the ring-buffer modular subtract.
package fir_tap_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One spare MSB so indices < LENGTH always leave the top bit at 0.
  function automatic int calc_addr_w(input int length);
    return $clog2(length) + 1;
  endfunction

  // No power-of-two assumption: a ring index of any length wraps correctly.
  function automatic int unsigned mod_sub(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned len);
    if (a >= b) return a - b;
    else        return a + len - b;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Handshake and memory/MAC control bundle between the tap sequencer and the FIR datapath.
// The master side is the sequencer; the slave side is the datapath and consumer.
interface fir_tap_sequencer_if #(parameter int LENGTH = 16);
  import fir_tap_seq_pkg::*;

  localparam int ADDR_W = calc_addr_w(LENGTH);

  logic              in_valid;
  logic              in_ready;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [ADDR_W-1:0] coeff_addr;
  logic [ADDR_W-1:0] samp_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  in_valid, out_ready,
    output in_ready, buf_we, buf_waddr, coeff_addr, samp_addr,
           mac_clr, mac_en, out_valid
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, buf_we, buf_waddr, coeff_addr, samp_addr,
           mac_clr, mac_en, out_valid
  );

endinterface

// File: rtl/fir_tap_sequencer_mod_counter.sv
// Modulo-MOD up-counter with enable, wrapping MOD-1 -> 0.
// Clear is synchronous and active-low.
module mod_counter
  import fir_tap_seq_pkg::*;
#(
  parameter int MOD = 16,
  parameter int W   = calc_addr_w(MOD)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)     r_count <= '0;
    else if (i_en)    r_count <= (r_count == W'(MOD - 1)) ? '0 : r_count + W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: walks all coefficient/sample taps per accepted sample and
// drives MAC clear/enable one cycle behind the reads. Option: FIR_TAP_SEQ_PERF_CNT_EN adds o_out_count.
//   state | meaning
//   IDLE  | ready for a sample; accept writes it to the ring buffer
//   RUN   | presenting taps 0..LENGTH-1
//   DRAIN | last MAC update for the final tap read
//   DONE  | result valid, waiting for the consumer
module fir_tap_sequencer
  import fir_tap_seq_pkg::*;
#(
  parameter int LENGTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fir_tap_sequencer_if.master  bus
`ifdef FIR_TAP_SEQ_PERF_CNT_EN
  , output logic [15:0]        o_out_count
`endif
);

  localparam int ADDR_W = calc_addr_w(LENGTH);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] w_wp, w_tap, r_newest;
  logic              w_accept, w_tap_en, w_tap_last;
  logic              r_mac_en, r_mac_clr;

  mod_counter #(.MOD(LENGTH), .W(ADDR_W)) u_wp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_accept),
    .o_count (w_wp)
  );

  // The tap counter wraps back to 0 on the last RUN cycle, so it is ready for the next walk.
  mod_counter #(.MOD(LENGTH), .W(ADDR_W)) u_tap (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_tap_en),
    .o_count (w_tap)
  );

  assign w_tap_last = (w_tap == ADDR_W'(LENGTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_tap_en      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.buf_we    = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = i_rst_n;
        if (bus.in_valid && i_rst_n) begin
          w_accept     = 1'b1;
          bus.buf_we   = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_tap_en = 1'b1;
        if (w_tap_last) w_state_next = DRAIN;
      end
      DRAIN: w_state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // MAC controls trail the address phase by the one-cycle memory read latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_newest  <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
    end else begin
      if (w_accept) r_newest <= w_wp;
      r_mac_en  <= (r_state == RUN);
      r_mac_clr <= (r_state == RUN) && (w_tap == '0);
    end
  end

  assign bus.buf_waddr  = w_wp;
  assign bus.coeff_addr = w_tap;
  assign bus.samp_addr  = ADDR_W'(mod_sub(32'(r_newest), 32'(w_tap), LENGTH));
  assign bus.mac_en     = r_mac_en;
  assign bus.mac_clr    = r_mac_clr;

`ifdef FIR_TAP_SEQ_PERF_CNT_EN
  logic [15:0] r_out_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                          r_out_count <= '0;
    else if (bus.out_valid && bus.out_ready) r_out_count <= r_out_count + 16'd1;
  end

  assign o_out_count = r_out_count;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer (LENGTH=5, non-power-of-two ring).
// Honours FIR_TAP_SEQ_PERF_CNT_EN when the design is built with it.
module tb_fir_tap_sequencer;

  localparam int L  = 5;
  localparam int AW = $clog2(L) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.LENGTH(L)) bus ();
`ifdef FIR_TAP_SEQ_PERF_CNT_EN
  logic [15:0] out_count;
`endif

  fir_tap_sequencer #(.LENGTH(L)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef FIR_TAP_SEQ_PERF_CNT_EN
    , .o_out_count (out_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int exp_wp  = 0;
  int exp_count = 0;

  // One full sample: accept, tap walk, optional consumer stall, handshake.
  task automatic do_sample(input int hold, input bit keep_valid, input bit immediate);
    int waited = 0;
    bit got = 1'b0;
    int newest;
    int tap;
    logic [4:0] exp_ctrl;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    n_total++;
    if (!got) begin
      $display("FAIL accept_timeout in_ready=%b want 1 within 40 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    n_pass++;
    if (immediate) begin
      n_total++;
      if (waited != 0) $display("FAIL b2b_gap extra_wait=%0d want 0", waited);
      else n_pass++;
    end
    n_total++;
    if (bus.buf_we !== 1'b1 || bus.buf_waddr !== AW'(exp_wp))
      $display("FAIL accept_write we=%b waddr=%0d want we=1 waddr=%0d",
               bus.buf_we, bus.buf_waddr, exp_wp);
    else n_pass++;
    newest = exp_wp;
    exp_wp = (exp_wp + 1) % L;

    for (int c = 1; c <= L + 2 + hold; c++) begin
      @(negedge clk);
      bus.in_valid  = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
      bus.out_ready = (c < L + 2) ? 1'($urandom_range(0, 1)) : (c == L + 2 + hold);
      #1;
      exp_ctrl = {(c >= 2 && c <= L + 1), (c == 2), (c >= L + 2), 1'b0, 1'b0};
      n_total++;
      if ({bus.mac_en, bus.mac_clr, bus.out_valid, bus.in_ready, bus.buf_we} !== exp_ctrl)
        $display("FAIL ctrl c=%0d en/clr/ov/rdy/we=%b want %b", c,
                 {bus.mac_en, bus.mac_clr, bus.out_valid, bus.in_ready, bus.buf_we}, exp_ctrl);
      else n_pass++;
      if (c <= L) begin
        tap = c - 1;
        n_total++;
        if (bus.coeff_addr !== AW'(tap) || bus.samp_addr !== AW'((newest + L - tap) % L))
          $display("FAIL tap_addr c=%0d coeff=%0d samp=%0d want coeff=%0d samp=%0d", c,
                   bus.coeff_addr, bus.samp_addr, tap, (newest + L - tap) % L);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_count = (exp_count + 1) % 65536;
`ifdef FIR_TAP_SEQ_PERF_CNT_EN
    n_total++;
    if (out_count !== 16'(exp_count)) $display("FAIL out_count got %0d want %0d", out_count, exp_count);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({bus.mac_en, bus.mac_clr, bus.out_valid, bus.in_ready, bus.buf_we} !== 5'b0)
      $display("FAIL reset_ctrl en/clr/ov/rdy/we=%b want 00000",
               {bus.mac_en, bus.mac_clr, bus.out_valid, bus.in_ready, bus.buf_we});
    else n_pass++;
    n_total++;
    if (bus.coeff_addr !== '0 || bus.samp_addr !== '0 || bus.buf_waddr !== '0)
      $display("FAIL reset_addr coeff=%0d samp=%0d waddr=%0d want 0 0 0",
               bus.coeff_addr, bus.samp_addr, bus.buf_waddr);
    else n_pass++;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b want 1", bus.in_ready);
    else n_pass++;
    exp_wp = 0;
    exp_count = 0;
`ifdef FIR_TAP_SEQ_PERF_CNT_EN
    n_total++;
    if (out_count !== 16'd0) $display("FAIL reset_count got %0d want 0", out_count);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_run();
    bit saw_ov = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.buf_we !== 1'b1)
      $display("FAIL midrst_accept rdy=%b we=%b want 1 1", bus.in_ready, bus.buf_we);
    else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (c == 3) rst_n = 1'b0;
    end
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL midrst_rdy_low in_ready=%b want 0", bus.in_ready);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({bus.mac_en, bus.mac_clr, bus.out_valid, bus.buf_we} !== 4'b0 || bus.coeff_addr !== '0 ||
        bus.buf_waddr !== '0)
      $display("FAIL midrst_state en/clr/ov/we=%b coeff=%0d waddr=%0d want 0000 0 0",
               {bus.mac_en, bus.mac_clr, bus.out_valid, bus.buf_we}, bus.coeff_addr, bus.buf_waddr);
    else n_pass++;
    rst_n = 1'b1;
    exp_wp = 0;
    exp_count = 0;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) saw_ov = 1'b1;
    end
    n_total++;
    if (saw_ov) $display("FAIL midrst_no_out out_valid seen=1 want 0");
    else n_pass++;
  endtask

  task automatic test_first_walk();
    do_sample(0, 1'b0, 1'b0);
  endtask

  task automatic test_wp_wrap();
    for (int s = 0; s < 6; s++) do_sample(0, 1'b0, 1'b0);
  endtask

  task automatic test_done_hold();
    do_sample(3, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) do_sample(0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++)
      do_sample(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_first_walk();
    test_wp_wrap();
    test_done_hold();
    test_reset_mid_run();
    test_first_walk();
    test_back_to_back();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
